// File: rtl/fcvtsw_pipe.sv
// rtl/fcvtsw_pipe.sv - 3-stage signed int32 to float32 converter (fcvt.s.w) with global stall
// Optional macro FCVTSW_INEXACT_EN adds a pipelined inexact flag output.
module fcvtsw_pipe #(
  parameter int RNE = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
`ifdef FCVTSW_INEXACT_EN
  ,
  output logic        inexact
`endif
);

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Position of the highest set bit, expressed as leading zeros; 0 for v == 0.
  function automatic logic [4:0] lzc(input logic [31:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = 5'(31 - i);
    end
    return n;
  endfunction

  // Stage 1: sign, magnitude, zero flag
  logic        v1, s1, z1;
  logic [31:0] mag1;
  logic [31:0] mag_d;

  assign mag_d = x[31] ? (~x + 32'd1) : x;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1   <= 1'b0;
      s1   <= 1'b0;
      z1   <= 1'b0;
      mag1 <= 32'd0;
    end else if (!stall) begin
      v1   <= in_valid;
      s1   <= x[31];
      z1   <= (x == 32'd0);
      mag1 <= mag_d;
    end
  end

  // Stage 2: normalize; the implicit leading one is dropped from the register
  logic        v2, s2, z2;
  logic [30:0] nrm2;
  logic [7:0]  e2;
  logic [4:0]  lz;
  logic [30:0] nrm_d;

  assign lz    = lzc(mag1);
  assign nrm_d = 31'(mag1 << lz);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2   <= 1'b0;
      s2   <= 1'b0;
      z2   <= 1'b0;
      nrm2 <= 31'd0;
      e2   <= 8'd0;
    end else if (!stall) begin
      v2   <= v1;
      s2   <= s1;
      z2   <= z1;
      nrm2 <= nrm_d;
      e2   <= 8'd158 - {3'd0, lz};
    end
  end

  // Stage 3: round and pack
  logic [22:0] man;
  logic        g, st, up;
  logic [23:0] sum;
  logic [7:0]  e3;
  logic [31:0] y_d;

  assign man = nrm2[30:8];
  assign g   = nrm2[7];
  assign st  = |nrm2[6:0];
  assign up  = (RNE != 0) ? (g && (st || man[0])) : g;
  assign sum = {1'b0, man} + {23'd0, up};
  // A mantissa carry leaves sum[22:0] at zero, so only the exponent needs bumping.
  assign e3  = e2 + {7'd0, sum[23]};
  assign y_d = z2 ? 32'h0000_0000 : {s2, e3, sum[22:0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      y         <= 32'h0000_0000;
    end else if (!stall) begin
      out_valid <= v2;
      y         <= y_d;
    end
  end

`ifdef FCVTSW_INEXACT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inexact <= 1'b0;
    end else if (!stall) begin
      inexact <= g || st;
    end
  end
`endif

endmodule

// File: doc/fcvtsw_pipe.md
Name: fcvtsw_pipe

Overview:
Pipelined signed-int32 to float32 converter (fcvt.s.w) for the FPU execute cluster. It is the producer side of the int/float conversion pair: its results feed the existing float-to-int converter on round-trip paths and write back to the FP register file. It has a 3-stage valid/ready pipeline with a global stall and accepts one operand per cycle when not stalled.

Parameters:
RNE, 0, rounding select: 0 = round-to-nearest ties-away-from-zero (matches float-to-int converter); 1 = round-to-nearest ties-to-even

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
in_valid  input  1  operand x valid
in_ready  output  1  converter can accept x this cycle
x  input  32  signed two's-complement integer
out_valid  output  1  y valid
out_ready  input  1  consumer accepts y this cycle
y  output  32  IEEE-754 single result

Behaviour:
- Reset: asynchronous on rstn low. All stage valid bits = 0, out_valid = 0, y = 32'h0. in_ready is driven high during and after reset (no stall possible while out_valid = 0).
- Handshake: input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- stall = out_valid && !out_ready. in_ready = !stall.
- While stalled, every stage register holds its value, including bubbles. There is no bubble collapse.
- Data registers may load when the valid bit is 0. Valid bits are never X.
- Latency: exactly 3 clk edges from accepted input to out_valid with no stall. Throughput is 1 per cycle. Order is preserved.
- S1 (capture):
  - s = x[31].
  - mag = s ? -x : x, as a 32-bit unsigned value. x = 32'h80000000 gives mag = 32'h80000000 (2^31).
  - z = (x == 0).
- S2 (normalize):
  - lz = leading-zero count of mag, 0..31.
  - nrm = mag << lz, so nrm[31] = 1 when mag != 0.
  - e = 8'd158 - lz.
- S3 (round/pack):
  - man = nrm[30:8]; g = nrm[7]; st = |nrm[6:0].
  - RNE=0: up = g.
  - RNE=1: up = g && (st || man[0]).
  - {c, man'} = man + up (24-bit sum).
  - If c = 1: man' = 0 and e = e + 1 (max e = 158, so no overflow to Inf is possible).
  - y = z ? 32'h00000000 : {s, e, man'}.
- Zero always produces +0.0. No NaN or Inf outputs and no exception output; every int32 is representable after rounding.
- Reset mid-operation: all in-flight operations are discarded. No output follows reset until new inputs are accepted.
- Simultaneous accept and drain in the same cycle is legal whenever !stall.

Optional Feature:
FCVTSW_INEXACT_EN
- Defined: adds output port inexact (1 bit), pipelined alongside y and valid with out_valid.
  - inexact = g || st (the dropped bits nonzero).
  - Reset value 0; held during stall.
- Undefined: the port and its logic are absent. y and timing are identical in both builds.

Test Plan:
- x=1, then x=-1 (32'hFFFFFFFF), back-to-back, out_ready=1 -> after 3 cycles, y=32'h3F800000 then 32'hBF800000 on consecutive cycles.
- x=0 -> y=32'h00000000. x=32'h80000000 -> y=32'hCF000000.
- x=32'h7FFFFFFF -> mantissa carry: y=32'h4F000000 (inexact=1 if enabled).
- x=32'h01000001 (2^24+1, exact tie):
  - RNE=0 -> y=32'h4B800001.
  - RNE=1 -> y=32'h4B800000.
  - inexact=1 in both.
- Backpressure:
  - Stream 4 values (3, -5, 100, 16777216).
  - Hold out_ready=0 for 5 cycles once out_valid rises.
  - Expect in_ready=0 while stalled and y held at 32'h40400000.
  - After release, expect 32'h40400000, 32'hC0A00000, 32'h42C80000, 32'h4B800000 in order with no loss or duplication.
- Assert rstn=0 asynchronously with 3 operations in flight -> out_valid=0 and y=0 immediately. After release, no stale output appears, and the next accepted x=2 yields 32'h40000000 3 cycles later.
